// File: rtl/tx_stream_pacer.sv
// Paces bursty freq/AM stream writes into one paired sample every DIVIDE clocks.
// Also tracks transmitter enable and raises a sticky flag when a sample is missed.
module tx_stream_pacer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DIVIDE  = 250,
  parameter int unsigned AM_BITS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        input_tx_freq,
  input  logic               input_tx_freq_stb,
  output logic               input_tx_freq_ack,
  input  logic [31:0]        input_tx_am,
  input  logic               input_tx_am_stb,
  output logic               input_tx_am_ack,
  input  logic [31:0]        input_tx_ctl,
  input  logic               input_tx_ctl_stb,
  output logic               input_tx_ctl_ack,
  output logic [31:0]        freq_word,
  output logic [AM_BITS-1:0] am_level,
  output logic               tx_en,
  output logic               sample_stb,
  output logic               underrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DIVIDE);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   HALF = (AW+1)'(DEPTH / 2);
  localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  logic [31:0]        freq_mem [DEPTH];
  logic [AM_BITS-1:0] am_mem   [DEPTH];
  logic [AW-1:0]      f_wr_q, f_rd_q, a_wr_q, a_rd_q;
  logic [AW:0]        f_cnt_q, a_cnt_q;
  logic [CW-1:0]      tick_q;
  state_t             state_q;
  logic               enable_q, tx_en_q, sample_stb_q, underrun_q;
  logic [31:0]        freq_word_q;
  logic [AM_BITS-1:0] am_level_q;

  logic ctl_fire, flush, en_d, f_push, a_push, tick, both_avail, pop;
  logic unused_bits;

  // A control word takes effect on its own accept edge, so a disable or flush
  // coinciding with a tick wins over the tick.
  always_comb begin
    input_tx_ctl_ack  = !rst;
    ctl_fire          = input_tx_ctl_stb && input_tx_ctl_ack;
    flush             = ctl_fire && input_tx_ctl[1];
    en_d              = ctl_fire ? input_tx_ctl[0] : enable_q;
    input_tx_freq_ack = !rst && (f_cnt_q != FULL) && !flush;
    input_tx_am_ack   = !rst && (a_cnt_q != FULL) && !flush;
    f_push            = input_tx_freq_stb && input_tx_freq_ack;
    a_push            = input_tx_am_stb && input_tx_am_ack;
    tick              = (state_q == RUN) && (tick_q == LAST);
    both_avail        = (f_cnt_q != '0) && (a_cnt_q != '0);
    pop               = tick && en_d && !flush && both_avail;
  end

  assign unused_bits = ^{input_tx_am[31:AM_BITS], input_tx_ctl[31:2]};

  always_ff @(posedge clk) begin
    if (f_push) freq_mem[f_wr_q] <= input_tx_freq;
    if (a_push) am_mem[a_wr_q]   <= input_tx_am[AM_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      f_wr_q  <= '0;
      f_rd_q  <= '0;
      f_cnt_q <= '0;
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      a_cnt_q <= '0;
    end else begin
      if (f_push) f_wr_q <= f_wr_q + 1'b1;
      if (a_push) a_wr_q <= a_wr_q + 1'b1;
      if (pop) begin
        f_rd_q <= f_rd_q + 1'b1;
        a_rd_q <= a_rd_q + 1'b1;
      end
      case ({f_push, pop})
        2'b10:   f_cnt_q <= f_cnt_q + 1'b1;
        2'b01:   f_cnt_q <= f_cnt_q - 1'b1;
        default: f_cnt_q <= f_cnt_q;
      endcase
      case ({a_push, pop})
        2'b10:   a_cnt_q <= a_cnt_q + 1'b1;
        2'b01:   a_cnt_q <= a_cnt_q - 1'b1;
        default: a_cnt_q <= a_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      tick_q       <= '0;
      tx_en_q      <= 1'b0;
      sample_stb_q <= 1'b0;
      underrun_q   <= 1'b0;
      freq_word_q  <= '0;
      am_level_q   <= '0;
    end else begin
      enable_q     <= en_d;
      sample_stb_q <= 1'b0;
      if (flush) underrun_q <= 1'b0;
      if (!en_d) begin
        state_q    <= IDLE;
        tx_en_q    <= 1'b0;
        am_level_q <= '0;
        tick_q     <= '0;
      end else begin
        tx_en_q <= 1'b1;
        case (state_q)
          IDLE: begin
            state_q <= PRIME;
            tick_q  <= '0;
          end
          PRIME: begin
            tick_q <= '0;
            if (!flush && (f_cnt_q >= HALF) && (a_cnt_q >= HALF)) state_q <= RUN;
          end
          default: begin
            if (flush) begin
              state_q    <= PRIME;
              am_level_q <= '0;
              tick_q     <= '0;
            end else if (tick) begin
              tick_q <= '0;
              if (both_avail) begin
                freq_word_q  <= freq_mem[f_rd_q];
                am_level_q   <= am_mem[a_rd_q];
                sample_stb_q <= 1'b1;
              end else begin
                underrun_q <= 1'b1;
                am_level_q <= '0;
                state_q    <= PRIME;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign freq_word  = freq_word_q;
  assign am_level   = am_level_q;
  assign tx_en      = tx_en_q;
  assign sample_stb = sample_stb_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_tx_stream_pacer.sv
// Self-checking bench for tx_stream_pacer: directed steps plus random traffic
// against a queue-based reference model that schedules samples by absolute edge number.
module tb_tx_stream_pacer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DIVIDE  = 4;
  localparam int unsigned AM_BITS = 10;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        f_data, a_data, c_data;
  logic               f_stb, a_stb, c_stb;
  logic               f_ack, a_ack, c_ack;
  logic [31:0]        freq_word;
  logic [AM_BITS-1:0] am_level;
  logic               tx_en, sample_stb, underrun;

  always #5 clk = ~clk;

  tx_stream_pacer #(.DEPTH(DEPTH), .DIVIDE(DIVIDE), .AM_BITS(AM_BITS)) dut (
    .clk(clk), .rst(rst),
    .input_tx_freq(f_data), .input_tx_freq_stb(f_stb), .input_tx_freq_ack(f_ack),
    .input_tx_am(a_data), .input_tx_am_stb(a_stb), .input_tx_am_ack(a_ack),
    .input_tx_ctl(c_data), .input_tx_ctl_stb(c_stb), .input_tx_ctl_ack(c_ack),
    .freq_word(freq_word), .am_level(am_level), .tx_en(tx_en),
    .sample_stb(sample_stb), .underrun(underrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queues for buffered samples, next sample due at edge `due`.
  logic [31:0]        fq[$];
  logic [AM_BITS-1:0] aq[$];
  int                 mode = M_IDLE;
  bit                 m_en = 1'b0;
  int                 edges = 0;
  int                 due = 0;
  logic [31:0]        m_freq = '0;
  logic [AM_BITS-1:0] m_am = '0;
  bit                 m_stb = 1'b0, m_under = 1'b0, m_txen = 1'b0;
  logic [31:0]        obs_f[$];
  logic [AM_BITS-1:0] obs_a[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    f_stb = 1'b0; a_stb = 1'b0; c_stb = 1'b0;
    f_data = '0; a_data = '0; c_data = '0;
  endtask

  task automatic cycle();
    bit fa, aa, ca, flush, en_new;
    #1;
    ca = !rst;
    flush = ca && c_stb && c_data[1];
    fa = ca && (fq.size() < DEPTH) && !flush;
    aa = ca && (aq.size() < DEPTH) && !flush;
    check("freq_ack", {31'b0, f_ack}, {31'b0, fa});
    check("am_ack",   {31'b0, a_ack}, {31'b0, aa});
    check("ctl_ack",  {31'b0, c_ack}, {31'b0, ca});
    edges++;
    m_stb = 1'b0;
    if (rst) begin
      fq.delete(); aq.delete();
      mode = M_IDLE; m_en = 1'b0; m_freq = '0; m_am = '0; m_under = 1'b0;
    end else begin
      en_new = c_stb ? c_data[0] : m_en;
      if (!en_new) begin
        mode = M_IDLE; m_am = '0;
      end else if (mode == M_IDLE) begin
        mode = M_PRIME;
      end else if (mode == M_PRIME) begin
        if (!flush && fq.size() >= DEPTH/2 && aq.size() >= DEPTH/2) begin
          mode = M_RUN; due = edges + DIVIDE;
        end
      end else if (flush) begin
        mode = M_PRIME; m_am = '0;
      end else if (edges == due) begin
        if (fq.size() > 0 && aq.size() > 0) begin
          m_freq = fq.pop_front(); m_am = aq.pop_front(); m_stb = 1'b1;
          due = due + DIVIDE;
        end else begin
          m_under = 1'b1; m_am = '0; mode = M_PRIME;
        end
      end
      if (flush) begin
        fq.delete(); aq.delete(); m_under = 1'b0;
      end else begin
        if (f_stb && fa) fq.push_back(f_data);
        if (a_stb && aa) aq.push_back(a_data[AM_BITS-1:0]);
      end
      m_en = en_new;
    end
    m_txen = (mode != M_IDLE);
    @(posedge clk);
    #1;
    check("freq_word",  freq_word, m_freq);
    check("am_level",   {22'b0, am_level}, {22'b0, m_am});
    check("tx_en",      {31'b0, tx_en}, {31'b0, m_txen});
    check("sample_stb", {31'b0, sample_stb}, {31'b0, m_stb});
    check("underrun",   {31'b0, underrun}, {31'b0, m_under});
    if (sample_stb === 1'b1) begin
      obs_f.push_back(freq_word);
      obs_a.push_back(am_level);
    end
  endtask

  task automatic ctl(input logic [31:0] w);
    idle_inputs();
    c_stb = 1'b1; c_data = w;
    cycle();
    idle_inputs();
  endtask

  task automatic push_pair(input logic [31:0] f, input logic [31:0] a);
    idle_inputs();
    f_stb = 1'b1; f_data = f; a_stb = 1'b1; a_data = a;
    cycle();
    idle_inputs();
  endtask

  initial begin
    int n0;
    bit found;
    int rate;
    idle_inputs();
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Enable: tx_en rises on the next cycle, nothing is emitted yet.
    ctl(32'h1);
    check("tx_en_after_ctl", {31'b0, tx_en}, 32'h1);
    cycle();

    // Four pairs in, four paced samples out, then an underrun.
    obs_f.delete(); obs_a.delete();
    for (int i = 0; i < 4; i++) push_pair(32'h1000 + i, 32'd10 + i);
    repeat (30) cycle();
    check("n_samples", obs_f.size(), 4);
    for (int i = 0; i < 4 && i < obs_f.size(); i++) begin
      check("seq_freq", obs_f[i], 32'h1000 + i);
      check("seq_am",   {22'b0, obs_a[i]}, 32'd10 + i);
    end
    check("underrun_set", {31'b0, underrun}, 32'h1);
    check("freq_held", freq_word, 32'h1003);

    ctl(32'h3);
    check("underrun_cleared", {31'b0, underrun}, 32'h0);

    // Freq only: fifo fills, back-pressure on the fifth word, no run starts.
    n0 = obs_f.size();
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      f_stb = 1'b1; f_data = 32'h2000 + i;
      cycle();
    end
    idle_inputs();
    repeat (10) cycle();
    check("no_stb_freq_only", obs_f.size(), n0);
    ctl(32'h3);

    // Flush with three pairs queued.
    for (int i = 0; i < 3; i++) push_pair(32'h3000 + i, 32'd20 + i);
    ctl(32'h3);
    cycle();

    // Disable landing exactly on a tick: no pop, no strobe.
    for (int i = 0; i < 3; i++) push_pair(32'h4000 + i, 32'd30 + i);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mode == M_RUN && edges + 1 == due) found = 1'b1;
      else cycle();
    end
    check("tick_reached", {31'b0, found}, 32'h1);
    ctl(32'h0);
    check("no_stb_on_disable", {31'b0, sample_stb}, 32'h0);
    repeat (3) cycle();
    ctl(32'h1);

    // Random traffic with varying producer rates and occasional control words.
    for (int blk = 0; blk < 8; blk++) begin
      rate = $urandom_range(0, 8);
      for (int i = 0; i < 60; i++) begin
        f_stb = ($urandom_range(0, rate) == 0);
        a_stb = ($urandom_range(0, rate) == 0);
        f_data = $urandom;
        a_data = $urandom;
        c_stb = ($urandom_range(0, 39) == 0);
        c_data = {$urandom_range(0, 1) == 0 ? 30'h0 : 30'h2aaa_aaaa,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0)};
        cycle();
      end
    end
    idle_inputs();

    // Reset in the middle of a run with three entries buffered.
    ctl(32'h3);
    for (int i = 0; i < 3; i++) push_pair(32'h5000 + i, 32'd40 + i);
    check("run_before_reset", mode, M_RUN);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
